// File: rtl/vif_stream_receiver.sv
// -----------------------------------------------------------------------------
// vif_stream_receiver
//   Consumer end of a data/valid/ready stream. Incoming beats are buffered in a
//   first-word-fall-through FIFO. The FIFO feeds a downstream valid/ready port.
//   Accepted input beats are counted.
//
// Optional feature macro: VIF_RX_PROTO_CHECK_EN
//   When defined, a sticky protocol checker flags an upstream producer that
//   drops in_valid or changes in_data while its beat is stalled. The flag is
//   cleared only by rst.
//   When undefined, proto_err is tied low and no checker logic is built.
//
// Parameters
//   DATA_W  width of in_data / out_data
//   DEPTH   FIFO entries (power of two, >= 2)
//   CNT_W   width of rx_count
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset (assert async, release sync)
//   flush      synchronous FIFO clear (does not touch rx_count / proto_err)
//   in_data    upstream data
//   in_valid   upstream valid
//   in_ready   upstream ready (FIFO not full)
//   out_data   head-of-FIFO data (meaningful only while out_valid)
//   out_valid  FIFO non-empty
//   out_ready  downstream accept
//   level      current occupancy, 0..DEPTH
//   rx_count   accepted input beats, wraps modulo 2**CNT_W
//   proto_err  sticky protocol error (0 when the checker is not built)
// -----------------------------------------------------------------------------
module vif_stream_receiver #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           rx_count,
  output logic                       proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [LVL_W-1:0] LVL_ONE       = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL      = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_NEAR_FULL = LVL_W'(DEPTH - 1);

  // Occupancy state, kept in lock-step with level_q. It exists so that the
  // handshake outputs come from a small registered encoding rather than from
  // a compare on the level counter.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  occ_e               occ_q, occ_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   rx_count_q, rx_count_d;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic push;
  logic pop;

  // Handshake outputs depend only on registered state, so there is no
  // combinational path from in_valid or out_ready. A full FIFO refuses a
  // beat even when a pop happens on the same edge.
  assign in_ready  = (occ_q != OCC_FULL);
  assign out_valid = (occ_q != OCC_EMPTY);

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // First-word-fall-through: the head entry is read combinationally.
  assign out_data = mem[rd_ptr_q];
  assign level    = level_q;
  assign rx_count = rx_count_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    occ_d      = occ_q;
    level_d    = level_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rx_count_d = rx_count_q;

    // Every accepted beat is counted. This includes a beat that a
    // simultaneous flush throws away.
    if (push) begin
      rx_count_d = rx_count_q + CNT_W'(1);
    end

    if (flush) begin
      occ_d    = OCC_EMPTY;
      level_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap without a compare.
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      unique case ({push, pop})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase

      unique case (occ_q)
        OCC_EMPTY: begin
          // A pop cannot happen while empty, so only a push moves us.
          if (push) begin
            occ_d = OCC_PARTIAL;
          end
        end
        OCC_PARTIAL: begin
          if (push && !pop && (level_q == LVL_NEAR_FULL)) begin
            occ_d = OCC_FULL;
          end else if (pop && !push && (level_q == LVL_ONE)) begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // A push cannot happen while full, so only a pop moves us.
          if (pop) begin
            occ_d = OCC_PARTIAL;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q      <= OCC_EMPTY;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rx_count_q <= '0;
    end else begin
      occ_q      <= occ_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rx_count_q <= rx_count_d;
    end
  end

  // Storage has no reset. Its contents are don't-care until written. A write
  // during a flush is harmless because the pointers return to zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional upstream protocol checker
  // ---------------------------------------------------------------------------
`ifdef VIF_RX_PROTO_CHECK_EN
  logic              prev_valid_q;
  logic              prev_ready_q;
  logic [DATA_W-1:0] prev_data_q;
  logic              proto_err_q;
  logic              violation;

  // A beat that was offered but not taken last cycle must still be offered
  // now, with the same data.
  assign violation = prev_valid_q & ~prev_ready_q &
                     (~in_valid | (in_data != prev_data_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_valid_q <= 1'b0;
      prev_ready_q <= 1'b1;
      prev_data_q  <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      prev_valid_q <= in_valid;
      prev_ready_q <= in_ready;
      prev_data_q  <= in_data;
      if (violation) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_vif_stream_receiver.sv
module tb_vif_stream_receiver;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst;
  logic              flush;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0]  rx_count;
  logic              proto_err;

  vif_stream_receiver #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level    (level),
    .rx_count (rx_count),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_failed = 0;

`ifdef VIF_RX_PROTO_CHECK_EN
  localparam logic EXP_PROTO_ERR = 1'b1;
`else
  localparam logic EXP_PROTO_ERR = 1'b0;
`endif

  // Scoreboard: beats expected to leave the FIFO, in order.
  logic [DATA_W-1:0] exp_q[$];
  logic [CNT_W-1:0]  m_rx;
  int                lvl_before;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act !== exp) begin
      checks_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Reference model of acceptance, flush and the beat counter. It is updated
  // on the same edges as the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_rx <= '0;
    end else begin
      if (in_valid && (lvl_before != DEPTH)) begin
        m_rx <= m_rx + CNT_W'(1);
        if (!flush) exp_q.push_back(in_data);
      end
      if (flush) exp_q.delete();
    end
  end

  // Monitor: compares the outputs against the model on the falling edge, then
  // retires the head beat if the downstream side takes it on the next edge.
  always @(negedge clk) begin
    if (rst) begin
      lvl_before <= 0;
    end else begin
      chk("mon_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("mon_level",     32'(level),     32'(exp_q.size()));
      chk("mon_in_ready",  32'(in_ready),  32'(exp_q.size() != DEPTH));
      chk("mon_rx_count",  32'(rx_count),  32'(m_rx));
      lvl_before <= exp_q.size();
      if ((exp_q.size() != 0) && out_ready) begin
        chk("mon_out_data", 32'(out_data), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [DATA_W-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    chk("reset_level",     32'(level),     32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready",  32'(in_ready),  32'd1);
    chk("reset_rx_count",  32'(rx_count),  32'd0);
    chk("reset_proto_err", 32'(proto_err), 32'd0);

    // Single beat
    push_beat(8'hA5);
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_out_data",  32'(out_data),  32'hA5);
    chk("single_level",     32'(level),     32'd1);
    chk("single_rx_count",  32'(rx_count),  32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_drained_level", 32'(level), 32'd0);

    // Fill to full, then hold a fifth beat
    for (int i = 1; i <= 4; i++) push_beat(8'(i));
    chk("fill_level",    32'(level),    32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    in_data = 8'h05; in_valid = 1'b1;
    step(); step();
    chk("fill_held_level", 32'(level),    32'd4);
    chk("fill_held_rx",    32'(rx_count), 32'd5);
    out_ready = 1'b1;
    step();                       // pop 01, the full FIFO refuses 05
    chk("fill_pop1_level", 32'(level),    32'd3);
    chk("fill_pop1_head",  32'(out_data), 32'h02);
    step();                       // 05 accepted, 02 popped
    in_valid = 1'b0;
    chk("fill_pop2_level", 32'(level),    32'd3);
    chk("fill_pop2_head",  32'(out_data), 32'h03);
    step(); step(); step();
    out_ready = 1'b0;
    chk("fill_drain_level", 32'(level),    32'd0);
    chk("fill_drain_rx",    32'(rx_count), 32'd6);

    // Concurrent push/pop at level 2 over 10 beats
    push_beat(8'h20);
    push_beat(8'h21);
    chk("conc_start_level", 32'(level), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(8'h10 + i); in_valid = 1'b1;
      step();
      chk("conc_level", 32'(level), 32'd2);
    end
    in_valid = 1'b0;
    step(); step();
    out_ready = 1'b0;
    chk("conc_end_level", 32'(level),    32'd0);
    chk("conc_end_rx",    32'(rx_count), 32'd18);

    // Flush with a simultaneous push
    push_beat(8'h40); push_beat(8'h41); push_beat(8'h42);
    chk("flush_pre_level", 32'(level), 32'd3);
    flush = 1'b1; in_data = 8'h43; in_valid = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_level",     32'(level),     32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_rx",        32'(rx_count),  32'd22);

    // Protocol violation while full
    for (int i = 0; i < 4; i++) push_beat(8'(8'h50 + i));
    in_data = 8'h33; in_valid = 1'b1;
    step();
    in_data = 8'h34;
    step();
    in_valid = 1'b0;
    step();
    chk("proto_err_set", 32'(proto_err), 32'(EXP_PROTO_ERR));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("proto_err_after_flush", 32'(proto_err), 32'(EXP_PROTO_ERR));
    chk("proto_flush_level",     32'(level),     32'd0);

    // Reset in the middle of a transfer
    push_beat(8'h60);
    in_data = 8'h61; in_valid = 1'b1;
    rst = 1'b1;
    #1;
    in_valid = 1'b0;
    chk("midrst_level",     32'(level),     32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_rx",        32'(rx_count),  32'd0);
    chk("midrst_proto_err", 32'(proto_err), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Operation resumes after reset
    push_beat(8'h70);
    chk("post_rst_data", 32'(out_data), 32'h70);
    chk("post_rst_rx",   32'(rx_count), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_rst_level", 32'(level), 32'd0);
    step();

    $display("%0d/%0d checks passed", checks_total - checks_failed, checks_total);
    $finish;
  end

endmodule
